// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall controller.
//   STALL_* : stall vector patterns, bit 0 = PC ... bit 5 = WB
//   STOP / NO_STOP : per-stage hold levels
//   mc_state_e : multi-cycle sequencer states
package pipe_stall_ctrl_pkg;

    localparam int unsigned STALL_W  = 6;
    localparam int unsigned STALL_PC = 0;

    typedef logic [STALL_W-1:0] stall_vec_t;

    localparam stall_vec_t STALL_NONE = 6'b000000;
    localparam stall_vec_t STALL_ID   = 6'b000111;
    localparam stall_vec_t STALL_EX   = 6'b001111;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_mc_seq_counter.sv
// Down-counter tracking the remaining hold cycles of a multi-cycle op.
//   clk, rst     : clock, async active-low reset
//   load         : load load_val (takes priority over dec)
//   clear        : force count to zero (takes priority over load)
//   dec          : decrement by one
//   load_val     : value loaded with load
//   zero_c       : combinational, high when count is zero
module pipe_stall_ctrl_mc_seq_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_q;

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges ID/EX stall requests, sequences
// multi-cycle EX ops, counts stalled cycles and flags protocol errors.
//   clk, rst        : clock, async active-low reset
//   stallreq_id/ex  : same-cycle stall requests from ID / EX
//   mc_start/mc_len : start pulse and hold length of a multi-cycle op
//   mc_done         : early completion (honoured only while busy)
//   mc_cancel       : abort in-flight op, clears the stall this cycle
//   stall           : combinational stall vector [0]PC..[5]WB
//   mc_busy         : combinational, high while sequencer is busy
//   err             : sticky, mc_start seen while busy
//   stall_cnt       : saturating count of cycles with stall[0] set
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned PERF_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               mc_start,
    input  logic [CNT_W-1:0]   mc_len,
    input  logic               mc_done,
    input  logic               mc_cancel,
    output logic [STALL_W-1:0] stall,
    output logic               mc_busy,
    output logic               err,
    output logic [PERF_W-1:0]  stall_cnt
);

    mc_state_e state_q, state_d;
    logic      hold_c;
    logic      cnt_load, cnt_clear, cnt_dec, cnt_zero_c;

    pipe_stall_ctrl_mc_seq_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .clear    (cnt_clear),
        .dec      (cnt_dec),
        .load_val (mc_len - CNT_W'(1)),
        .zero_c   (cnt_zero_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, hold request and counter controls
    always_comb begin
        state_d   = state_q;
        hold_c    = NO_STOP;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Zero-length ops and start+cancel never hold
                if (mc_start && !mc_cancel && (mc_len != '0)) begin
                    hold_c   = STOP;
                    cnt_load = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mc_cancel) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_zero_c || mc_done) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_c  = STOP;
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall merge; gated by reset so the vector drops asynchronously
    always_comb begin
        stall = STALL_NONE;
        if (!rst || mc_cancel) begin
            stall = STALL_NONE;
        end else if ((hold_c == STOP) || stallreq_ex) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end
    end

    assign mc_busy = (state_q == ST_BUSY);

    // Sticky protocol error: a new op started while one is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((state_q == ST_BUSY) && mc_start) begin
            err <= 1'b1;
        end
    end

    // Saturating stalled-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((stall[STALL_PC] == STOP) && (stall_cnt != {PERF_W{1'b1}})) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: the driver pushes the expected
// per-cycle outputs from an op-age reference model; a monitor on the
// falling edge pops and compares.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, mc_start, mc_done, mc_cancel;
    logic [5:0]  mc_len;
    logic [5:0]  stall;
    logic        mc_busy, err;
    logic [15:0] stall_cnt;

    pipe_stall_ctrl #(.CNT_W(6), .PERF_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .mc_start    (mc_start),
        .mc_len      (mc_len),
        .mc_done     (mc_done),
        .mc_cancel   (mc_cancel),
        .stall       (stall),
        .mc_busy     (mc_busy),
        .err         (err),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  stall;
        logic        busy;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: op length and age (cycles since its start cycle)
    bit m_busy = 0;
    int m_len  = 0;
    int m_age  = 0;
    bit m_err  = 0;
    int m_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_len = 0; m_age = 0; m_err = 0; m_cnt = 0;
    endtask

    // One clock of stimulus plus its expected outputs
    task automatic step(input bit id, input bit ex, input bit st, input int len,
                        input bit dn, input bit cn);
        bit   hold, start_new, end_op;
        exp_t e;
        @(posedge clk);
        #1;
        stallreq_id = id; stallreq_ex = ex; mc_start = st;
        mc_len = 6'(len); mc_done = dn; mc_cancel = cn;
        hold = 0; start_new = 0; end_op = 0;
        if (!m_busy) begin
            if (st && !cn && len != 0) begin hold = 1; start_new = 1; end
        end else begin
            // An op of length L holds during ages 0..L-1
            if (!cn && !dn && m_age < m_len) hold = 1;
            else end_op = 1;
        end
        e.stall = cn ? 6'b000000 : (hold || ex) ? 6'b001111 : id ? 6'b000111 : 6'b000000;
        e.busy  = m_busy;
        e.err   = m_err;
        e.cnt   = 16'(m_cnt);
        q.push_back(e);
        if (e.stall[0]) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        if (st && m_busy) m_err = 1;
        if (start_new) begin
            m_busy = 1; m_len = len; m_age = 1;
        end else if (m_busy) begin
            if (end_op) m_busy = 0;
            else m_age++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cyc++;
                chk($sformatf("cycle%0d {stall,busy,err,cnt}", cyc),
                    32'({stall, mc_busy, err, stall_cnt}), 32'(e));
            end
        end
    end

    initial begin
        rst = 1'b0;
        stallreq_id = 1; stallreq_ex = 1; mc_start = 1; mc_len = 6'd5;
        mc_done = 1; mc_cancel = 0;
        #12;
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_cnt", 32'(stall_cnt), 32'h0);
        chk("reset_busy", 32'(mc_busy), 32'h0);
        stallreq_id = 0; stallreq_ex = 0; mc_start = 0; mc_done = 0;
        #6 rst = 1'b1;

        // Priority
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        idle(2);
        // Full length 5
        step(0, 0, 1, 5, 0, 0);
        idle(7);
        // Early done in 3rd busy cycle
        step(0, 0, 1, 20, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 0);
        idle(2);
        // Cancel in 2nd busy cycle, then start+cancel
        step(0, 0, 1, 10, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 1, 7, 0, 1);
        idle(2);
        // Edge lengths
        step(0, 0, 1, 0, 0, 0);
        idle(1);
        step(0, 0, 1, 1, 0, 0);
        idle(3);
        step(0, 0, 1, 63, 0, 0);
        idle(66);
        // Requests during busy and done while idle
        step(0, 0, 1, 4, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 1, 0);
        // mc_start while busy
        step(0, 0, 1, 6, 0, 0);
        step(0, 0, 1, 3, 0, 0);
        idle(8);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 8) == 0,
                 (($urandom % 10) == 0) ? 63 : int'($urandom_range(0, 12)),
                 ($urandom % 12) == 0, ($urandom % 16) == 0);
        end
        idle(70);

        // Async reset mid-op
        step(0, 0, 1, 10, 0, 0);
        step(0, 0, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_stall", 32'(stall), 32'h0);
        chk("async_rst_busy", 32'(mc_busy), 32'h0);
        chk("async_rst_err", 32'(err), 32'h0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        chk("post_rst_cnt", 32'(stall_cnt), 32'h0);
        idle(3);

        // Saturation of the stall counter
        for (int i = 0; i < 65600; i++) step(1, 0, 0, 0, 0, 0);
        idle(2);

        @(negedge clk);
        #1;
        chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
